// File: rtl/riscv_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_rf_wb_arbiter
//
// Arbitrates two writeback requesters (0: ALU, 1: LSU) onto the single
// register-file write port and keeps a pending-write scoreboard for the issue
// stage.
//
// Build option:
//   RF_WB_ROUND_ROBIN_EN  defined   -> one-bit round-robin priority pointer.
//                         undefined -> requester 0 always has priority and no
//                                      pointer state exists.
//
// Ports:
//   clk                 single clock, rising-edge
//   reset               asynchronous active-low reset
//   wb0_valid_i/ready_o requester 0 handshake (ready is combinational grant)
//   wb0_addr_i/data_i   requester 0 destination register / data
//   wb1_valid_i/ready_o requester 1 handshake (ready is combinational grant)
//   wb1_addr_i/data_i   requester 1 destination register / data
//   rf_wr_en_o          registered regfile write enable (never for x0)
//   rf_wr_addr_o        registered regfile write address
//   rf_wr_data_o        registered regfile write data
//   sb_set_i            issue stage marks sb_set_addr_i pending
//   sb_set_addr_i       register to mark pending
//   rs0_addr_i/rs1_addr_i issue-stage source registers
//   rs0_busy_o/rs1_busy_o combinational pending flags for those sources
// -----------------------------------------------------------------------------
module riscv_rf_wb_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        wb0_valid_i,
  output logic        wb0_ready_o,
  input  logic [4:0]  wb0_addr_i,
  input  logic [31:0] wb0_data_i,

  input  logic        wb1_valid_i,
  output logic        wb1_ready_o,
  input  logic [4:0]  wb1_addr_i,
  input  logic [31:0] wb1_data_i,

  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_addr_o,
  output logic [31:0] rf_wr_data_o,

  input  logic        sb_set_i,
  input  logic [4:0]  sb_set_addr_i,

  input  logic [4:0]  rs0_addr_i,
  input  logic [4:0]  rs1_addr_i,
  output logic        rs0_busy_o,
  output logic        rs1_busy_o
);

  localparam int unsigned DataW   = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned NumRegs = 32;

  // ---------------------------------------------------------------------------
  // Priority selection
  // ---------------------------------------------------------------------------
  // w_prio1 = 1 means requester 1 wins when both are valid.
  logic w_prio1;
  logic w_grant0;
  logic w_grant1;

`ifdef RF_WB_ROUND_ROBIN_EN
  logic r_prio;
  logic w_prio_d;

  assign w_prio1 = r_prio;

  // Pointer moves to the requester that was not granted; holds when idle.
  always_comb begin
    w_prio_d = r_prio;
    if (w_grant0) begin
      w_prio_d = 1'b1;
    end else if (w_grant1) begin
      w_prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio <= 1'b0;
    end else begin
      r_prio <= w_prio_d;
    end
  end
`else
  assign w_prio1 = 1'b0;
`endif

  // Grants are qualified with reset so both readies read 0 while in reset.
  always_comb begin
    w_grant0 = reset & wb0_valid_i & (~wb1_valid_i | ~w_prio1);
    w_grant1 = reset & wb1_valid_i & (~wb0_valid_i |  w_prio1);
  end

  assign wb0_ready_o = w_grant0;
  assign wb1_ready_o = w_grant1;

  // ---------------------------------------------------------------------------
  // Transfer mux
  // ---------------------------------------------------------------------------
  logic             w_xfer;
  logic [AddrW-1:0] w_xfer_addr;
  logic [DataW-1:0] w_xfer_data;

  always_comb begin
    w_xfer      = w_grant0 | w_grant1;
    w_xfer_addr = w_grant1 ? wb1_addr_i : wb0_addr_i;
    w_xfer_data = w_grant1 ? wb1_data_i : wb0_data_i;
  end

  // ---------------------------------------------------------------------------
  // Registered regfile write port
  // ---------------------------------------------------------------------------
  logic             r_wr_en;
  logic [AddrW-1:0] r_wr_addr;
  logic [DataW-1:0] r_wr_data;

  // x0 transfers still capture addr/data but never raise the enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_xfer && (w_xfer_addr != '0);
      if (w_xfer) begin
        r_wr_addr <= w_xfer_addr;
        r_wr_data <= w_xfer_data;
      end
    end
  end

  assign rf_wr_en_o   = r_wr_en;
  assign rf_wr_addr_o = r_wr_addr;
  assign rf_wr_data_o = r_wr_data;

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
  logic [NumRegs-1:0] r_busy;
  logic [NumRegs-1:0] w_busy_d;

  // Clear on transfer first so a same-cycle set of the same register wins.
  always_comb begin
    w_busy_d = r_busy;
    if (w_xfer) begin
      w_busy_d[w_xfer_addr] = 1'b0;
    end
    if (sb_set_i && (sb_set_addr_i != '0)) begin
      w_busy_d[sb_set_addr_i] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Source busy lookup
  // ---------------------------------------------------------------------------
  // The busy bit is cleared as the transfer completes, but the data only lands
  // in the regfile one cycle later, so the in-flight write also counts.
  logic w_rs0_inflight;
  logic w_rs1_inflight;

  always_comb begin
    w_rs0_inflight = r_wr_en && (r_wr_addr == rs0_addr_i);
    w_rs1_inflight = r_wr_en && (r_wr_addr == rs1_addr_i);
    rs0_busy_o     = 1'b0;
    rs1_busy_o     = 1'b0;
    if (rs0_addr_i != '0) begin
      rs0_busy_o = r_busy[rs0_addr_i] | w_rs0_inflight;
    end
    if (rs1_addr_i != '0) begin
      rs1_busy_o = r_busy[rs1_addr_i] | w_rs1_inflight;
    end
  end

  // At most one transfer per cycle.
  grant_onehot_a : assert property (@(posedge clk) disable iff (!reset)
                                    !(w_grant0 && w_grant1));

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
module tb_riscv_rf_wb_arbiter;

`ifdef RF_WB_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wb0_valid_i, wb0_ready_o;
  logic [4:0]  wb0_addr_i;
  logic [31:0] wb0_data_i;
  logic        wb1_valid_i, wb1_ready_o;
  logic [4:0]  wb1_addr_i;
  logic [31:0] wb1_data_i;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_addr_o;
  logic [31:0] rf_wr_data_o;
  logic        sb_set_i;
  logic [4:0]  sb_set_addr_i;
  logic [4:0]  rs0_addr_i, rs1_addr_i;
  logic        rs0_busy_o, rs1_busy_o;

  riscv_rf_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .wb0_valid_i  (wb0_valid_i),
    .wb0_ready_o  (wb0_ready_o),
    .wb0_addr_i   (wb0_addr_i),
    .wb0_data_i   (wb0_data_i),
    .wb1_valid_i  (wb1_valid_i),
    .wb1_ready_o  (wb1_ready_o),
    .wb1_addr_i   (wb1_addr_i),
    .wb1_data_i   (wb1_data_i),
    .rf_wr_en_o   (rf_wr_en_o),
    .rf_wr_addr_o (rf_wr_addr_o),
    .rf_wr_data_o (rf_wr_data_o),
    .sb_set_i     (sb_set_i),
    .sb_set_addr_i(sb_set_addr_i),
    .rs0_addr_i   (rs0_addr_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs0_busy_o   (rs0_busy_o),
    .rs1_busy_o   (rs1_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];

  // Expected write appears on the port in the cycle after the transfer.
  task automatic expect_write(input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every asserted write must match the head of the expected queue.
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_write got=none expected addr=%0d data=%h cyc=%0d",
               e.addr, e.data, e.cyc);
    end
    if (rf_wr_en_o === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL spurious_write got addr=%0d data=%h cyc=%0d expected=no write",
                 rf_wr_addr_o, rf_wr_data_o, cyc);
      end else begin
        e = q.pop_front();
        if (rf_wr_addr_o !== e.addr || rf_wr_data_o !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL wb_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                   rf_wr_addr_o, rf_wr_data_o, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    wb0_valid_i   = 1'b1;
    wb0_addr_i    = 5'd1;
    wb0_data_i    = 32'h1;
    wb1_valid_i   = 1'b1;
    wb1_addr_i    = 5'd2;
    wb1_data_i    = 32'h2;
    sb_set_i      = 1'b0;
    sb_set_addr_i = 5'd0;
    rs0_addr_i    = 5'd3;
    rs1_addr_i    = 5'd0;

    // Reset state, with both requesters valid.
    #2 reset = 1'b0;
    #1;
    chk("rst_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
    chk("rst_wr_addr", {27'b0, rf_wr_addr_o}, 32'd0);
    chk("rst_wr_data", rf_wr_data_o, 32'd0);
    chk("rst_ready0", {31'b0, wb0_ready_o}, 32'd0);
    chk("rst_ready1", {31'b0, wb1_ready_o}, 32'd0);
    chk("rst_rs0_busy", {31'b0, rs0_busy_o}, 32'd0);
    nxt();
    nxt();
    wb0_valid_i = 1'b0;
    wb1_valid_i = 1'b0;
    reset       = 1'b1;

    // Single write from requester 0.
    nxt();
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd5;
    wb0_data_i  = 32'hDEADBEEF;
    expect_write(5'd5, 32'hDEADBEEF);
    #1;
    chk("single_ready0", {31'b0, wb0_ready_o}, 32'd1);
    chk("single_ready1", {31'b0, wb1_ready_o}, 32'd0);
    nxt();
    wb0_valid_i = 1'b0;
    #1;
    chk("single_en_n1", {31'b0, rf_wr_en_o}, 32'd1);
    nxt();
    chk("single_en_n2", {31'b0, rf_wr_en_o}, 32'd0);

    // Contention starting from reset.
    nxt();
    reset = 1'b0;
    nxt();
    reset       = 1'b1;
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd1;
    wb0_data_i  = 32'h1111_0001;
    wb1_valid_i = 1'b1;
    wb1_addr_i  = 5'd2;
    wb1_data_i  = 32'h2222_0002;
    for (int i = 0; i < 4; i++) begin
      logic g1;
      if (i > 0) nxt();
      g1 = RoundRobin && (i % 2 == 1);
      if (g1) expect_write(5'd2, 32'h2222_0002);
      else    expect_write(5'd1, 32'h1111_0001);
      #1;
      chk($sformatf("contend_ready0_%0d", i), {31'b0, wb0_ready_o}, {31'b0, !g1});
      chk($sformatf("contend_ready1_%0d", i), {31'b0, wb1_ready_o}, {31'b0, g1});
    end
    nxt();
    wb0_valid_i = 1'b0;
    expect_write(5'd2, 32'h2222_0002);
    #1;
    chk("lone1_ready1", {31'b0, wb1_ready_o}, 32'd1);
    chk("lone1_ready0", {31'b0, wb0_ready_o}, 32'd0);
    nxt();
    wb1_valid_i = 1'b0;

    // Write to x0: handshake completes, no enable, addr/data still captured.
    nxt();
    wb1_valid_i = 1'b1;
    wb1_addr_i  = 5'd0;
    wb1_data_i  = 32'h12345678;
    #1;
    chk("x0_ready1", {31'b0, wb1_ready_o}, 32'd1);
    nxt();
    wb1_valid_i = 1'b0;
    #1;
    chk("x0_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
    chk("x0_wr_addr", {27'b0, rf_wr_addr_o}, 32'd0);
    chk("x0_wr_data", rf_wr_data_o, 32'h12345678);

    // Scoreboard set, in-flight visibility and clear.
    nxt();
    sb_set_i      = 1'b1;
    sb_set_addr_i = 5'd7;
    rs0_addr_i    = 5'd7;
    rs1_addr_i    = 5'd0;
    #1;
    chk("sb_busy_n", {31'b0, rs0_busy_o}, 32'd0);
    nxt();
    sb_set_i = 1'b0;
    #1;
    chk("sb_busy_n1", {31'b0, rs0_busy_o}, 32'd1);
    chk("sb_rs1_x0", {31'b0, rs1_busy_o}, 32'd0);
    nxt();
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd7;
    wb0_data_i  = 32'h0000_0777;
    expect_write(5'd7, 32'h0000_0777);
    #1;
    chk("sb_busy_m", {31'b0, rs0_busy_o}, 32'd1);
    nxt();
    wb0_valid_i = 1'b0;
    rs1_addr_i  = 5'd7;
    #1;
    chk("sb_inflight_m1", {31'b0, rs0_busy_o}, 32'd1);
    chk("sb_inflight_rs1", {31'b0, rs1_busy_o}, 32'd1);
    nxt();
    chk("sb_clear_m2", {31'b0, rs0_busy_o}, 32'd0);

    // Set and write to the same register together: set wins.
    nxt();
    sb_set_i      = 1'b1;
    sb_set_addr_i = 5'd7;
    wb0_valid_i   = 1'b1;
    wb0_data_i    = 32'h0000_7777;
    expect_write(5'd7, 32'h0000_7777);
    nxt();
    sb_set_i    = 1'b0;
    wb0_valid_i = 1'b0;
    #1;
    chk("setwin_busy1", {31'b0, rs0_busy_o}, 32'd1);
    nxt();
    chk("setwin_busy2", {31'b0, rs0_busy_o}, 32'd1);
    nxt();
    wb1_valid_i = 1'b1;
    wb1_addr_i  = 5'd7;
    wb1_data_i  = 32'h0000_0007;
    expect_write(5'd7, 32'h0000_0007);
    nxt();
    wb1_valid_i = 1'b0;
    nxt();
    chk("setwin_cleared", {31'b0, rs0_busy_o}, 32'd0);

    // Reset mid-transfer with busy bits 3 and 9 set.
    nxt();
    sb_set_i      = 1'b1;
    sb_set_addr_i = 5'd3;
    nxt();
    sb_set_addr_i = 5'd9;
    nxt();
    sb_set_i    = 1'b0;
    rs0_addr_i  = 5'd3;
    rs1_addr_i  = 5'd9;
    wb0_valid_i = 1'b1;
    wb0_addr_i  = 5'd4;
    wb0_data_i  = 32'h4444_4444;
    expect_write(5'd4, 32'h4444_4444);
    #1;
    chk("prerst_rs0", {31'b0, rs0_busy_o}, 32'd1);
    chk("prerst_rs1", {31'b0, rs1_busy_o}, 32'd1);
    chk("prerst_ready0", {31'b0, wb0_ready_o}, 32'd1);
    nxt();
    wb0_addr_i = 5'd10;
    wb0_data_i = 32'hAAAA_AAAA;
    #1;
    chk("prerst_wr_en", {31'b0, rf_wr_en_o}, 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
    chk("midrst_wr_addr", {27'b0, rf_wr_addr_o}, 32'd0);
    chk("midrst_wr_data", rf_wr_data_o, 32'd0);
    chk("midrst_ready0", {31'b0, wb0_ready_o}, 32'd0);
    chk("midrst_rs0", {31'b0, rs0_busy_o}, 32'd0);
    chk("midrst_rs1", {31'b0, rs1_busy_o}, 32'd0);
    nxt();
    wb0_valid_i = 1'b0;
    reset       = 1'b1;
    #1;
    chk("postrst_wr_en", {31'b0, rf_wr_en_o}, 32'd0);
    chk("postrst_rs0", {31'b0, rs0_busy_o}, 32'd0);
    chk("postrst_rs1", {31'b0, rs1_busy_o}, 32'd0);
    nxt();
    chk("postrst_wr_en2", {31'b0, rf_wr_en_o}, 32'd0);

    repeat (3) nxt();
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
